// File: rtl/wb_regfile_sp.sv
// Write-back endpoint: commits WB-stage control to a 4x8 register file (R3 = stack pointer),
// the output port register and the sticky halt latch; exposes bypassed decode read ports.
module wb_regfile_sp #(
    parameter int          DW       = 8,
    parameter logic [DW-1:0] SP_RESET = 8'hFF,
    parameter bit          IN_SYNC  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    ra_wb,
    input  logic [1:0]    rb_wb,
    input  logic [DW-1:0] wb_data,
    input  logic [DW-1:0] in_port,
    input  logic          write_en,
    input  logic          sw1,
    input  logic          sw2,
    input  logic          sp_inc,
    input  logic          sp_dec,
    input  logic          ld_out,
    input  logic          hlt_en,
    input  logic [1:0]    rd_addr_a,
    input  logic [1:0]    rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic [DW-1:0] sp,
    output logic [DW-1:0] out_port,
    output logic          out_strobe,
    output logic          halted
);

    logic [DW-1:0] regs_r [0:3];
    logic [DW-1:0] out_port_r;
    logic          out_strobe_r;
    logic          halted_r;

    logic [DW-1:0] in_s;
    logic          active_s;
    logic          we_s;
    logic          inc_s;
    logic          dec_s;
    logic          ld_s;
    logic [1:0]    wdest_s;
    logic [DW-1:0] wdata_s;
    logic [DW-1:0] sp_pend_s;
    logic [DW-1:0] sp_next_s;
    logic          sp_move_s;

    generate
        if (IN_SYNC) begin : g_sync
            logic [DW-1:0] sync1_r;
            logic [DW-1:0] sync2_r;

            // Two-flop synchronizer for the asynchronous input port
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_r <= {DW{1'b0}};
                    sync2_r <= {DW{1'b0}};
                end else begin
                    sync1_r <= in_port;
                    sync2_r <= sync1_r;
                end
            end

            assign in_s = sync2_r;
        end else begin : g_nosync
            assign in_s = in_port;
        end
    endgenerate

    // An instruction carrying hlt_en, or anything arriving once halted, commits nothing but the halt
    assign active_s  = ~halted_r & ~hlt_en;
    assign we_s      = write_en & active_s;
    assign inc_s     = sp_inc   & active_s;
    assign dec_s     = sp_dec   & active_s;
    assign ld_s      = ld_out   & active_s;
    assign wdest_s   = sw1 ? rb_wb : ra_wb;
    assign wdata_s   = sw2 ? in_s : wb_data;
    assign sp_move_s = inc_s ^ dec_s;

    // Next stack pointer: a register write to R3 overrides push/pop arithmetic
    always_comb begin
        sp_pend_s = regs_r[3];
        sp_next_s = regs_r[3];
        if (sp_move_s) begin
            if (inc_s) begin
                sp_pend_s = regs_r[3] + {{(DW-1){1'b0}}, 1'b1};
            end else begin
                sp_pend_s = regs_r[3] - {{(DW-1){1'b0}}, 1'b1};
            end
        end else begin
            sp_pend_s = regs_r[3];
        end
        if (we_s && (wdest_s == 2'd3)) begin
            sp_next_s = wdata_s;
        end else begin
            sp_next_s = sp_pend_s;
        end
    end

    // Read port A with write and SP bypass
    always_comb begin
        rd_data_a = regs_r[rd_addr_a];
        if (we_s && (wdest_s == rd_addr_a)) begin
            rd_data_a = wdata_s;
        end else if ((rd_addr_a == 2'd3) && sp_move_s) begin
            rd_data_a = sp_pend_s;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Read port B with write and SP bypass
    always_comb begin
        rd_data_b = regs_r[rd_addr_b];
        if (we_s && (wdest_s == rd_addr_b)) begin
            rd_data_b = wdata_s;
        end else if ((rd_addr_b == 2'd3) && sp_move_s) begin
            rd_data_b = sp_pend_s;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

    // Architectural state update; reset discards any same-edge request
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_r[0]    <= {DW{1'b0}};
            regs_r[1]    <= {DW{1'b0}};
            regs_r[2]    <= {DW{1'b0}};
            regs_r[3]    <= SP_RESET;
            out_port_r   <= {DW{1'b0}};
            out_strobe_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            if (we_s && (wdest_s != 2'd3)) begin
                regs_r[wdest_s] <= wdata_s;
            end
            regs_r[3] <= sp_next_s;
            if (ld_s) begin
                out_port_r <= wb_data;
            end
            out_strobe_r <= ld_s;
            if (hlt_en) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign sp         = regs_r[3];
    assign out_port   = out_port_r;
    assign out_strobe = out_strobe_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_wb_regfile_sp.sv
// Directed bench for wb_regfile_sp: reset, bypass, SP wrap, POP priority, IN/OUT, halt and reset recovery.
module tb_wb_regfile_sp;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ra_wb, rb_wb, rd_addr_a, rd_addr_b;
    logic [7:0] wb_data, in_port;
    logic       write_en, sw1, sw2, sp_inc, sp_dec, ld_out, hlt_en;
    logic [7:0] rd_data_a, rd_data_b, sp, out_port;
    logic       out_strobe, halted;

    int vecs = 0;
    int errs = 0;

    wb_regfile_sp dut (
        .clk(clk), .rst(rst), .ra_wb(ra_wb), .rb_wb(rb_wb), .wb_data(wb_data),
        .in_port(in_port), .write_en(write_en), .sw1(sw1), .sw2(sw2),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .ld_out(ld_out), .hlt_en(hlt_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .sp(sp), .out_port(out_port),
        .out_strobe(out_strobe), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra_wb = 2'd0; rb_wb = 2'd0; wb_data = 8'h00;
        write_en = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
        sp_inc = 1'b0; sp_dec = 1'b0; ld_out = 1'b0; hlt_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); in_port = 8'h00; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
        step(); step();
        rst = 1'b0; #1;
        vecs++; if (sp !== 8'hFF) begin errs++; $display("FAIL reset_sp: got %h want %h", sp, 8'hFF); end
        vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted: got %b want 0", halted); end
        vecs++; if (out_port !== 8'h00) begin errs++; $display("FAIL reset_out_port: got %h want 00", out_port); end
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", out_strobe); end
        vecs++; if (rd_data_a !== 8'h00) begin errs++; $display("FAIL reset_r0: got %h want 00", rd_data_a); end
        vecs++; if (rd_data_b !== 8'h00) begin errs++; $display("FAIL reset_r1: got %h want 00", rd_data_b); end
        rd_addr_a = 2'd2; #1;
        vecs++; if (rd_data_a !== 8'h00) begin errs++; $display("FAIL reset_r2: got %h want 00", rd_data_a); end
    endtask

    task automatic test_write_bypass();
        write_en = 1'b1; sw1 = 1'b0; ra_wb = 2'd1; rb_wb = 2'd2; wb_data = 8'h5A;
        rd_addr_a = 2'd1; rd_addr_b = 2'd3; #1;
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL bypass_a: got %h want 5a", rd_data_a); end
        vecs++; if (rd_data_b !== 8'hFF) begin errs++; $display("FAIL no_bypass_b: got %h want ff", rd_data_b); end
        step(); idle(); #1;
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL commit_r1: got %h want 5a", rd_data_a); end
    endtask

    task automatic test_sp_wrap();
        sp_inc = 1'b1; rd_addr_b = 2'd3; #1;
        vecs++; if (rd_data_b !== 8'h00) begin errs++; $display("FAIL sp_pending_inc: got %h want 00", rd_data_b); end
        step(); idle(); #1;
        vecs++; if (sp !== 8'h00) begin errs++; $display("FAIL sp_inc_wrap: got %h want 00", sp); end
        sp_dec = 1'b1; step(); idle(); #1;
        vecs++; if (sp !== 8'hFF) begin errs++; $display("FAIL sp_dec_wrap: got %h want ff", sp); end
        sp_inc = 1'b1; sp_dec = 1'b1; #1;
        vecs++; if (rd_data_b !== 8'hFF) begin errs++; $display("FAIL sp_both_bypass: got %h want ff", rd_data_b); end
        step(); idle(); #1;
        vecs++; if (sp !== 8'hFF) begin errs++; $display("FAIL sp_both: got %h want ff", sp); end
    endtask

    task automatic test_pop();
        sp_inc = 1'b1; write_en = 1'b1; sw1 = 1'b1; rb_wb = 2'd3; ra_wb = 2'd0; wb_data = 8'h40;
        rd_addr_a = 2'd3; #1;
        vecs++; if (rd_data_a !== 8'h40) begin errs++; $display("FAIL pop_bypass: got %h want 40", rd_data_a); end
        step(); idle(); #1;
        vecs++; if (sp !== 8'h40) begin errs++; $display("FAIL pop_sp: got %h want 40", sp); end
        write_en = 1'b1; sw1 = 1'b0; ra_wb = 2'd0; wb_data = 8'h11; sp_dec = 1'b1;
        step(); idle(); rd_addr_a = 2'd0; #1;
        vecs++; if (rd_data_a !== 8'h11) begin errs++; $display("FAIL r0_with_dec: got %h want 11", rd_data_a); end
        vecs++; if (sp !== 8'h3F) begin errs++; $display("FAIL dec_with_r0: got %h want 3f", sp); end
    endtask

    task automatic test_in_port();
        in_port = 8'hC3;
        step(); step(); step();
        write_en = 1'b1; sw1 = 1'b1; sw2 = 1'b1; rb_wb = 2'd2; ra_wb = 2'd1; wb_data = 8'h00;
        rd_addr_a = 2'd2; #1;
        vecs++; if (rd_data_a !== 8'hC3) begin errs++; $display("FAIL in_bypass: got %h want c3", rd_data_a); end
        step(); idle(); #1;
        vecs++; if (rd_data_a !== 8'hC3) begin errs++; $display("FAIL in_r2: got %h want c3", rd_data_a); end
    endtask

    task automatic test_out_port();
        ld_out = 1'b1; wb_data = 8'h77;
        step(); idle(); #1;
        vecs++; if (out_port !== 8'h77) begin errs++; $display("FAIL out_port: got %h want 77", out_port); end
        vecs++; if (out_strobe !== 1'b1) begin errs++; $display("FAIL strobe_on: got %b want 1", out_strobe); end
        step();
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL strobe_off: got %b want 0", out_strobe); end
        vecs++; if (out_port !== 8'h77) begin errs++; $display("FAIL out_hold: got %h want 77", out_port); end
    endtask

    task automatic test_back_to_back();
        ld_out = 1'b1; wb_data = 8'h01;
        step(); wb_data = 8'h02; #1;
        vecs++; if (out_port !== 8'h01) begin errs++; $display("FAIL b2b_first: got %h want 01", out_port); end
        vecs++; if (out_strobe !== 1'b1) begin errs++; $display("FAIL b2b_strobe1: got %b want 1", out_strobe); end
        step(); idle(); #1;
        vecs++; if (out_port !== 8'h02) begin errs++; $display("FAIL b2b_second: got %h want 02", out_port); end
        vecs++; if (out_strobe !== 1'b1) begin errs++; $display("FAIL b2b_strobe2: got %b want 1", out_strobe); end
        step();
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL b2b_strobe_end: got %b want 0", out_strobe); end
    endtask

    task automatic test_halt();
        hlt_en = 1'b1; write_en = 1'b1; sw1 = 1'b0; ra_wb = 2'd1; wb_data = 8'h99;
        ld_out = 1'b1; sp_dec = 1'b1; rd_addr_a = 2'd1; rd_addr_b = 2'd3; #1;
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL hlt_no_bypass: got %h want 5a", rd_data_a); end
        step(); idle(); #1;
        vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halted_set: got %b want 1", halted); end
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL hlt_r1: got %h want 5a", rd_data_a); end
        vecs++; if (sp !== 8'h3F) begin errs++; $display("FAIL hlt_sp: got %h want 3f", sp); end
        vecs++; if (out_port !== 8'h02) begin errs++; $display("FAIL hlt_port: got %h want 02", out_port); end
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL hlt_strobe: got %b want 0", out_strobe); end
        write_en = 1'b1; ra_wb = 2'd1; wb_data = 8'hAA; ld_out = 1'b1; sp_dec = 1'b1; #1;
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL halted_bypass_a: got %h want 5a", rd_data_a); end
        vecs++; if (rd_data_b !== 8'h3F) begin errs++; $display("FAIL halted_bypass_sp: got %h want 3f", rd_data_b); end
        step(); step(); idle(); #1;
        vecs++; if (rd_data_a !== 8'h5A) begin errs++; $display("FAIL halted_r1: got %h want 5a", rd_data_a); end
        vecs++; if (sp !== 8'h3F) begin errs++; $display("FAIL halted_sp: got %h want 3f", sp); end
        vecs++; if (out_port !== 8'h02) begin errs++; $display("FAIL halted_port: got %h want 02", out_port); end
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL halted_strobe: got %b want 0", out_strobe); end
        vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halted_sticky: got %b want 1", halted); end
    endtask

    task automatic test_reset_mid_op();
        rst = 1'b1; write_en = 1'b1; ra_wb = 2'd0; wb_data = 8'hEE; ld_out = 1'b1; sp_inc = 1'b1;
        step(); rst = 1'b0; idle(); rd_addr_a = 2'd0; rd_addr_b = 2'd1; #1;
        vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b want 0", halted); end
        vecs++; if (sp !== 8'hFF) begin errs++; $display("FAIL rst_sp: got %h want ff", sp); end
        vecs++; if (out_port !== 8'h00) begin errs++; $display("FAIL rst_port: got %h want 00", out_port); end
        vecs++; if (out_strobe !== 1'b0) begin errs++; $display("FAIL rst_strobe: got %b want 0", out_strobe); end
        vecs++; if (rd_data_a !== 8'h00) begin errs++; $display("FAIL rst_r0: got %h want 00", rd_data_a); end
        vecs++; if (rd_data_b !== 8'h00) begin errs++; $display("FAIL rst_r1: got %h want 00", rd_data_b); end
        rd_addr_a = 2'd2; #1;
        vecs++; if (rd_data_a !== 8'h00) begin errs++; $display("FAIL rst_r2: got %h want 00", rd_data_a); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_sp_wrap();
        test_pop();
        test_in_port();
        test_out_port();
        test_back_to_back();
        test_halt();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
